// File: rtl/alu_op_sequencer.sv
// Command-issue front end for the 8-bit ALU: queues commands, issues them one at a time,
// waits out the ALU latency and holds the result. Optional opcode screening: ALU_SEQ_OPCHECK_EN.
module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [3:0]               cmd_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [3:0]               alu_s,
    output logic                     alu_rw,
    input  logic [7:0]               alu_f,
    input  logic [5:0]               alu_flags,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_f,
    output logic [5:0]               res_flags,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    logic [7:0]    mem_a  [DEPTH];
    logic [7:0]    mem_b  [DEPTH];
    logic [3:0]    mem_op [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          push;
    logic          pop;
    logic          full;

    assign full       = (count == CW'(DEPTH));
    assign cmd_ready  = rst & ~full;
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == ST_IDLE) && (count != '0);
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE) || (count != '0);

    // Storage carries data only; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_SEQ_OPCHECK_EN
    logic res_err_q;
    assign res_err = res_err_q;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b0010) || (op == 4'b0100) || (op == 4'b0101) ||
               (op == 4'b0110) || (op == 4'b0111);
    endfunction
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_rw    <= 1'b0;
            res_valid <= 1'b0;
            res_f     <= '0;
            res_flags <= '0;
`ifdef ALU_SEQ_OPCHECK_EN
            res_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
`ifdef ALU_SEQ_OPCHECK_EN
                        // Rejected opcodes never reach the ALU; the error result uses the same slot.
                        if (is_illegal(mem_op[rd_ptr])) begin
                            state     <= ST_RESULT;
                            res_valid <= 1'b1;
                            res_f     <= '0;
                            res_flags <= '0;
                            res_err_q <= 1'b1;
                        end else begin
                            alu_a     <= mem_a[rd_ptr];
                            alu_b     <= mem_b[rd_ptr];
                            alu_s     <= mem_op[rd_ptr];
                            alu_rw    <= 1'b1;
                            cnt       <= CNT_INIT;
                            res_err_q <= 1'b0;
                            state     <= ST_WAIT;
                        end
`else
                        alu_a  <= mem_a[rd_ptr];
                        alu_b  <= mem_b[rd_ptr];
                        alu_s  <= mem_op[rd_ptr];
                        alu_rw <= 1'b1;
                        cnt    <= CNT_INIT;
                        state  <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        res_f     <= alu_f;
                        res_flags <= alu_flags;
                        res_valid <= 1'b1;
                        alu_rw    <= 1'b0;
                        state     <= ST_RESULT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU in the loop.
// Define ALU_SEQ_OPCHECK_EN to also exercise the illegal-opcode path.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_rw;
    logic [7:0] alu_f;
    logic [5:0] alu_flags;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_f;
    logic [5:0] res_flags;
    logic       res_err;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       busy;

    typedef struct packed {
        logic [7:0] f;
        logic [5:0] flags;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_rw(alu_rw),
        .alu_f(alu_f), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_flags(res_flags), .res_err(res_err),
        .fifo_count(fifo_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: 0000 add, 0001 sub, 1000 and, 1001 or, 1010 xor, 1011 not-A.
    always_comb begin
        logic [8:0] t9;
        logic       c;
        logic       ov;
        t9    = '0;
        c     = 1'b0;
        ov    = 1'b0;
        alu_f = '0;
        case (alu_s)
            4'b0000: begin
                t9 = {1'b0, alu_a} + {1'b0, alu_b};
                alu_f = t9[7:0];
                c = t9[8];
                ov = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            4'b0001: begin
                t9 = {1'b0, alu_a} - {1'b0, alu_b};
                alu_f = t9[7:0];
                c = t9[8];
                ov = (alu_a[7] != alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            4'b1000: alu_f = alu_a & alu_b;
            4'b1001: alu_f = alu_a | alu_b;
            4'b1010: alu_f = alu_a ^ alu_b;
            4'b1011: alu_f = ~alu_a;
            default: alu_f = '0;
        endcase
        alu_flags = {(alu_f == 8'h00), c, ov, (alu_a == alu_b), (alu_a > alu_b), (alu_a < alu_b)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: pops on every result handshake and verifies held results stay frozen.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_f;
    logic [5:0] prev_flags;
    logic       prev_err;
    always @(negedge clk) begin
        if (rst === 1'b1 && prev_hold)
            chk("held_result", {19'd0, res_valid, res_f, res_flags, res_err},
                {19'd0, 1'b1, prev_f, prev_flags, prev_err});
        if (rst === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                timeout_fail("unexpected_result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_f", 32'(res_f), 32'(e.f));
                chk("res_flags", 32'(res_flags), 32'(e.flags));
                chk("res_err", 32'(res_err), 32'(e.err));
            end
        end
        prev_hold  = (rst === 1'b1) && (res_valid === 1'b1) && (res_ready === 1'b0);
        prev_f     = res_f;
        prev_flags = res_flags;
        prev_err   = res_err;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [7:0] f, input logic [5:0] fl, input logic err,
                        input bit expect_res);
        bit acc;
        acc       = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) timeout_fail("cmd_accept");
        else if (expect_res) begin
            exp_t e;
            e.f     = f;
            e.flags = fl;
            e.err   = err;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            done = !busy && !res_valid;
        end
        if (!done) timeout_fail("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = 8'h55;
        cmd_b     = 8'hAA;
        cmd_op    = 4'b0000;
        res_ready = 1'b1;

        // Reset held for three edges with a command pending
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outputs", {6'd0, alu_a, alu_b, alu_s, alu_rw, res_valid, res_err, busy},
            32'd0);
        chk("rst_res", {18'd0, res_f, res_flags}, 32'd0);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single add: issue one edge after acceptance, result one edge later
        send(8'h08, 8'h02, 4'b0000, 8'h0A, 6'b000010, 1'b0, 1'b1);
        chk("add_res_valid_early", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("add_alu_s", 32'(alu_s), 32'h0);
        chk("add_alu_a", 32'(alu_a), 32'h08);
        chk("add_alu_rw", 32'(alu_rw), 32'd1);
        @(posedge clk);
        #1;
        chk("add_res_valid", 32'(res_valid), 32'd1);
        chk("add_alu_rw_done", 32'(alu_rw), 32'd0);
        wait_idle();

        // Subtracts: equal operands, then borrow
        send(8'hF0, 8'hF0, 4'b0001, 8'h00, 6'b100100, 1'b0, 1'b1);
        send(8'h02, 8'h08, 4'b0001, 8'hFA, 6'b010001, 1'b0, 1'b1);
        wait_idle();

        // Backpressure: one result held, FIFO fills to DEPTH
        res_ready = 1'b0;
        send(8'hCC, 8'hAA, 4'b1000, 8'h88, 6'b000010, 1'b0, 1'b1);
        send(8'hCC, 8'hAA, 4'b1010, 8'h66, 6'b000010, 1'b0, 1'b1);
        send(8'hCC, 8'hAA, 4'b1001, 8'hEE, 6'b000010, 1'b0, 1'b1);
        send(8'hCC, 8'hAA, 4'b1011, 8'h33, 6'b000010, 1'b0, 1'b1);
        send(8'h0F, 8'hF0, 4'b1000, 8'h00, 6'b100001, 1'b0, 1'b1);
        chk("full_count", 32'(fifo_count), 32'(DEPTH));
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_res_valid", 32'(res_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = 8'h11;
        cmd_op    = 4'b0000;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("full_no_write", 32'(fifo_count), 32'(DEPTH));
        repeat (3) @(posedge clk);
        #1;
        chk("held_f", 32'(res_f), 32'h88);
        res_ready = 1'b1;
        wait_idle();
        chk("drain_scoreboard", 32'(sb.size()), 32'd0);

        // Reset during WAIT with two commands still queued
        res_ready = 1'b0;
        send(8'h7F, 8'h01, 4'b0000, 8'h80, 6'b001010, 1'b0, 1'b1);
        send(8'h01, 8'h01, 4'b0000, 8'h00, 6'b000000, 1'b0, 1'b0);
        send(8'h02, 8'h01, 4'b0000, 8'h00, 6'b000000, 1'b0, 1'b0);
        send(8'h03, 8'h01, 4'b0000, 8'h00, 6'b000000, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_wait_rw", 32'(alu_rw), 32'd1);
        chk("mid_wait_count", 32'(fifo_count), 32'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_alu", {11'd0, alu_a, alu_b, alu_s, alu_rw}, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst       = 1'b1;
        res_ready = 1'b1;
        seen      = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

`ifdef ALU_SEQ_OPCHECK_EN
        // Illegal opcode is screened, next legal one issues normally
        send(8'h08, 8'h02, 4'b0101, 8'h00, 6'b000000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("opchk_alu_rw", 32'(alu_rw), 32'd0);
        send(8'h08, 8'h02, 4'b1000, 8'h00, 6'b100010, 1'b0, 1'b1);
        wait_idle();
`endif

        wait_idle();
        chk("final_scoreboard", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-issue front end for the 8-bit ALU core: accepts operation commands (A, B, opcode) over a valid/ready stream, buffers them in a small FIFO, drives them one at a time onto the ALU operand/select/R_W pins, waits the ALU's fixed latency, then captures F and the six flags into a result register presented on a valid/ready output stream. It sits between the system command source and the ALU core, and is the issuing counterpart to the ALU's operand interface.

## Interface
- DEPTH, 4: command FIFO entries; power of two, 2–16.
- ALU_LAT, 1: cycles from ALU input change to stable F/flags; 1–15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; = !full, forced 0 while rst=0.
- cmd_a, cmd_b  in  8 each  operands.
- cmd_op  in  4  ALU select code.
- alu_a, alu_b  out  8 each  registered operands to ALU A/B.
- alu_s  out  4  registered select to ALU s.
- alu_rw  out  1  ALU R_W; 1 while an operation is in flight (WAIT), else 0.
- alu_f  in  8  ALU result F.
- alu_flags  in  6  {zeroflag, CarryOut, overflow, EQ, GT, LT}.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_f  out  8  captured F.
- res_flags  out  6  captured flags, same order.
- res_err  out  1  illegal opcode (OPCHECK build only; else tied 0).
- fifo_count  out  $clog2(DEPTH)+1  queued commands.
- busy  out  1  state != IDLE or fifo_count != 0.

## Operation
- Reset (rst=0 at an edge): FIFO emptied, pending commands dropped, state IDLE; alu_a=alu_b=0, alu_s=0, alu_rw=0, res_valid=0, res_f=0, res_flags=0, res_err=0, fifo_count=0, busy=0.
- FIFO: push on cmd_valid && cmd_ready; no write when full (cmd_ready=0); pointers wrap modulo DEPTH; simultaneous push and pop with FIFO non-full: count unchanged, both performed.
- FSM states IDLE, WAIT, RESULT.
  - IDLE: if FIFO non-empty, pop head, load alu_a/alu_b/alu_s, alu_rw←1, cnt←ALU_LAT-1, go WAIT; else hold.
  - WAIT: if cnt==0, capture alu_f→res_f, alu_flags→res_flags, res_valid←1, alu_rw←0, go RESULT; else cnt−1.
  - RESULT: hold res_* stable; on res_valid && res_ready, res_valid←0, go IDLE. No new issue while RESULT is held (single result slot).
- alu_a/alu_b/alu_s keep last issued values outside WAIT.
- Opcode is passed through unmodified; the sequencer does no arithmetic.

## Timing
- Command accepted at edge N with FIFO empty and state IDLE: ALU inputs change at edge N+1; result captured and res_valid high after edge N+1+ALU_LAT (ALU_LAT=1: N+2).
- res_ready held high: next issue at the edge after the result handshake; throughput one operation per ALU_LAT+2 cycles.
- res_valid stays high with res_* constant until accepted; backpressure never drops results; FIFO continues filling to DEPTH.
- Reset mid-WAIT or mid-RESULT: in-flight and held results discarded, outputs take reset values at that edge.

## Configuration
- ALU_SEQ_OPCHECK_EN defined: opcodes 0010, 0100, 0101, 0110, 0111 are illegal; on popping one, no ALU issue occurs (alu_* unchanged, alu_rw stays 0); the next edge goes to RESULT with res_f=0, res_flags=0, res_err=1. Legal results carry res_err=0.
- Undefined: every opcode issued to the ALU; res_err tied 0.

## Test plan
- Reset: hold rst=0 for 3 cycles with cmd_valid=1 → cmd_ready=0, all outputs at reset values, fifo_count=0 after release.
- Single add: A=0x08, B=0x02, op=0000, ALU_LAT=1, res_ready=1 → alu_s=0000 at N+1, res_valid after N+2, res_f=0x0A, zeroflag=0.
- Flagged subtract: A=0xF0, B=0xF0, op=0001 → res_f=0x00, zeroflag=1, EQ=1; then A=0x02, B=0x08, op=0001 → res_f=0xFA, LT=1.
- Backpressure/full: res_ready=0, push DEPTH+1 commands → one result held, cmd_ready drops when fifo_count=DEPTH; release res_ready → results emerge in order, each matching AND/XOR/OR/NOT reference values.
- Reset mid-operation: rst=0 during WAIT with 2 queued → res_valid never asserts for them, fifo_count=0.
- OPCHECK build: op=0101 → alu_rw stays 0, res_err=1, res_f=0; following op=1000 (0x08 & 0x02) → res_f=0x00, zeroflag=1, res_err=0.
